concat_1_reg: RTL and testbench
===============================

Name: concat_1_reg

Overview:
- Registered significand-prep stage of the FP adder datapath.
- Prepends the implicit (hidden) leading bit to two 23-bit IEEE-754 single-precision fractions, producing 24-bit significands.
- Optionally swaps operands so the larger-exponent operand appears on output 1.
- Sits between exponent compare/swap-decision logic and the alignment shifter.

Parameters:
- MANT_W, 23, fraction width; outputs are MANT_W+1 bits wide.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  qualifies sig1/sig2/n_concat/swap this cycle
- sig1  input  MANT_W  fraction of operand 1
- sig2  input  MANT_W  fraction of operand 2
- n_concat  input  2  hidden bits: [1] belongs to sig1, [0] belongs to sig2 (1 = normal, 0 = zero/denormal)
- swap  input  1  1 = exchange operands on output
- out_valid  output  1  registered in_valid
- sig1_concat  output  MANT_W+1  significand for output lane 1
- sig2_concat  output  MANT_W+1  significand for output lane 2

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Combinational pre-result:
  - a = {n_concat[1], sig1}
  - b = {n_concat[0], sig2}
  - swap=0: lane1 = a, lane2 = b.
  - swap=1: lane1 = b, lane2 = a.
  - No other bit manipulation; fraction bits pass unchanged. The hidden bit always travels with its own fraction.
- Latency: exactly 1 cycle.
  - At each rising clk with rst=0 and in_valid=1: sig1_concat <= lane1, sig2_concat <= lane2, out_valid <= 1.
  - At rising clk with rst=0 and in_valid=0: out_valid <= 0; sig1_concat/sig2_concat hold their previous values.
- No backpressure: a new operand pair is accepted every cycle (throughput 1/cycle).
- Reset: when rst=1 at a rising edge, sig1_concat=0, sig2_concat=0 and out_valid=0, regardless of in_valid.
  - Reset asserted mid-stream discards the in-flight result.
  - The first valid output after reset deassert appears one cycle after the first in_valid=1 with rst=0.
- Boundary cases:
  - n_concat=00 with all-zero fractions yields two 24-bit zeros.
  - n_concat=11 with all-ones fractions yields 24'hFFFFFF on both lanes.
  - swap with identical inputs produces identical outputs.
- X-free: no internal state beyond the output registers.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1, sig1=23'h7FFFFF, sig2=23'h7FFFFF, n_concat=11 -> sig1_concat=0, sig2_concat=0, out_valid=0. After rst=0 for one edge -> sig1_concat=sig2_concat=24'hFFFFFF, out_valid=1.
- No swap: sig1=23'h400000, sig2=23'h000001, n_concat=10, swap=0, in_valid=1 -> next cycle sig1_concat=24'hC00000, sig2_concat=24'h000001.
- Swap: same inputs as the no-swap case with swap=1 -> sig1_concat=24'h000001, sig2_concat=24'hC00000.
- Hidden-bit mapping: sig1=sig2=23'h123456, n_concat=01, swap=0 -> sig1_concat=24'h123456, sig2_concat=24'h923456. With swap=1 -> sig1_concat=24'h923456, sig2_concat=24'h123456.
- Hold/valid: after a valid transfer, drive in_valid=0 with changed inputs for 3 cycles -> outputs unchanged, out_valid=0. A back-to-back valid stream of 10 random vectors -> each result appears exactly 1 cycle later, in order, matching the lane equations.
- Reset mid-stream: assert rst during a valid stream -> next edge zeros the outputs and clears out_valid. Streaming resumes correctly one cycle after rst deasserts.

Source files
------------

// File: rtl/concat_1_reg.sv
// Registered significand-prep stage for the FP adder: attaches each operand's
// hidden bit to its fraction and optionally swaps the two operand lanes.
module concat_1_reg #(
  parameter int MANT_W = 23
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [MANT_W-1:0] sig1,
  input  logic [MANT_W-1:0] sig2,
  input  logic [1:0]        n_concat,
  input  logic              swap,
  output logic              out_valid,
  output logic [MANT_W:0]   sig1_concat,
  output logic [MANT_W:0]   sig2_concat
);

  logic [MANT_W:0] sig_a;
  logic [MANT_W:0] sig_b;
  logic [MANT_W:0] lane1;
  logic [MANT_W:0] lane2;

  // The hidden bit stays with its own fraction; the swap moves whole significands.
  always_comb begin
    sig_a = {n_concat[1], sig1};
    sig_b = {n_concat[0], sig2};
    lane1 = swap ? sig_b : sig_a;
    lane2 = swap ? sig_a : sig_b;
  end

  // Data registers hold on idle cycles so downstream sees stable values.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      sig1_concat <= '0;
      sig2_concat <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sig1_concat <= lane1;
        sig2_concat <= lane2;
      end
    end
  end

endmodule

// File: tb/tb_concat_1_reg.sv
// Self-checking bench for concat_1_reg: an arithmetic reference model checked
// every cycle, plus directed vectors with hand-computed expected outputs.
module tb_concat_1_reg;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [22:0] sig1;
  logic [22:0] sig2;
  logic [1:0]  n_concat;
  logic        swap;
  logic        out_valid;
  logic [23:0] sig1_concat;
  logic [23:0] sig2_concat;

  int total = 0;
  int bad   = 0;

  logic [23:0] model_lane1;
  logic [23:0] model_lane2;
  logic        model_valid;
  bit          model_known = 0;

  concat_1_reg #(.MANT_W(23)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .sig1        (sig1),
    .sig2        (sig2),
    .n_concat    (n_concat),
    .swap        (swap),
    .out_valid   (out_valid),
    .sig1_concat (sig1_concat),
    .sig2_concat (sig2_concat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a significand is the fraction plus 2^23 when the operand is normal.
  always @(posedge clk) begin
    int unsigned op1;
    int unsigned op2;
    op1 = int'(sig1) + (n_concat[1] ? 32'd8388608 : 32'd0);
    op2 = int'(sig2) + (n_concat[0] ? 32'd8388608 : 32'd0);
    if (rst) begin
      model_lane1 <= 24'd0;
      model_lane2 <= 24'd0;
      model_valid <= 1'b0;
    end else begin
      model_valid <= in_valid;
      if (in_valid) begin
        model_lane1 <= 24'(swap ? op2 : op1);
        model_lane2 <= 24'(swap ? op1 : op2);
      end
    end
    model_known <= 1'b1;
  end

  // Every-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (model_known) begin
      total++;
      if (out_valid !== model_valid || sig1_concat !== model_lane1 ||
          sig2_concat !== model_lane2) begin
        bad++;
        $display("[TB] FAIL model_cmp t=%0t: got v=%b l1=%h l2=%h, expected v=%b l1=%h l2=%h",
                 $time, out_valid, sig1_concat, sig2_concat,
                 model_valid, model_lane1, model_lane2);
      end
    end
  end

  task automatic applyStimulus(input logic r, input logic v, input logic [22:0] s1,
                               input logic [22:0] s2, input logic [1:0] nc,
                               input logic sw);
    rst      = r;
    in_valid = v;
    sig1     = s1;
    sig2     = s2;
    n_concat = nc;
    swap     = sw;
    @(posedge clk);
    #3;
  endtask

  task automatic checkOutput(input string name, input logic [23:0] exp1,
                             input logic [23:0] exp2, input logic expv);
    total++;
    if (sig1_concat !== exp1 || sig2_concat !== exp2 || out_valid !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got l1=%h l2=%h v=%b, expected l1=%h l2=%h v=%b",
               name, sig1_concat, sig2_concat, out_valid, exp1, exp2, expv);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; sig1 = '0; sig2 = '0; n_concat = '0; swap = 1'b0;

    $display("[TB] reset with valid inputs present");
    applyStimulus(1, 1, 23'h7FFFFF, 23'h7FFFFF, 2'b11, 0);
    checkOutput("reset_c1", 24'h000000, 24'h000000, 0);
    applyStimulus(1, 1, 23'h7FFFFF, 23'h7FFFFF, 2'b11, 0);
    checkOutput("reset_c2", 24'h000000, 24'h000000, 0);
    applyStimulus(0, 1, 23'h7FFFFF, 23'h7FFFFF, 2'b11, 0);
    checkOutput("after_reset_ones", 24'hFFFFFF, 24'hFFFFFF, 1);

    $display("[TB] lane mapping");
    applyStimulus(0, 1, 23'h400000, 23'h000001, 2'b10, 0);
    checkOutput("no_swap", 24'hC00000, 24'h000001, 1);
    applyStimulus(0, 1, 23'h400000, 23'h000001, 2'b10, 1);
    checkOutput("swap", 24'h000001, 24'hC00000, 1);
    applyStimulus(0, 1, 23'h123456, 23'h123456, 2'b01, 0);
    checkOutput("hidden_no_swap", 24'h123456, 24'h923456, 1);
    applyStimulus(0, 1, 23'h123456, 23'h123456, 2'b01, 1);
    checkOutput("hidden_swap", 24'h923456, 24'h123456, 1);

    $display("[TB] hold while idle");
    applyStimulus(0, 0, 23'h0ABCDE, 23'h7F0000, 2'b11, 0);
    checkOutput("hold_1", 24'h923456, 24'h123456, 0);
    applyStimulus(0, 0, 23'h111111, 23'h222222, 2'b00, 1);
    checkOutput("hold_2", 24'h923456, 24'h123456, 0);
    applyStimulus(0, 0, 23'h333333, 23'h444444, 2'b10, 0);
    checkOutput("hold_3", 24'h923456, 24'h123456, 0);

    $display("[TB] boundary vectors");
    applyStimulus(0, 1, 23'h000000, 23'h000000, 2'b00, 0);
    checkOutput("all_zero", 24'h000000, 24'h000000, 1);
    applyStimulus(0, 1, 23'h2AAAAA, 23'h2AAAAA, 2'b11, 1);
    checkOutput("swap_identical", 24'hAAAAAA, 24'hAAAAAA, 1);

    $display("[TB] back-to-back random stream");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 1, 23'($urandom), 23'($urandom), 2'($urandom), 1'($urandom));
    end

    $display("[TB] reset in the middle of a stream");
    applyStimulus(0, 1, 23'h7FFFFF, 23'h000000, 2'b10, 1);
    checkOutput("pre_midreset", 24'h000000, 24'hFFFFFF, 1);
    applyStimulus(1, 1, 23'h555555, 23'h555555, 2'b11, 0);
    checkOutput("midreset", 24'h000000, 24'h000000, 0);
    applyStimulus(0, 1, 23'h400000, 23'h000001, 2'b10, 0);
    checkOutput("resume", 24'hC00000, 24'h000001, 1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 23'($urandom), 23'($urandom), 2'($urandom), 1'($urandom));
    end
    applyStimulus(0, 0, 23'h0, 23'h0, 2'b00, 0);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
